mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
// - MEM-stage load/store unit; producer end of the MEM->WB interface.
// - Takes the EX/MEM op and drives the data-memory valid/ready bus.
// - Stalls upstream while an access is in flight.
// - Presents per-op results (alu_out, extended mem_out, wb controls) to the MEM/WB pipeline register.
// PARAMETERS
// - DATA_WIDTH      32  data/address width (RV32)
// - PC_WIDTH        32  PC width
// - REG_ADDR_WIDTH  5   regfile index width
// - WB_SEL_WIDTH    2   width of reg_wb_sel (REG_WRITE_BACK_SEL_LENGTH)
// PORTS
// - clk            in   1      clock, rising edge
// - rst            in   1      reset, asynchronous, active-high
// - in_valid       in   1      EX/MEM op valid
// - in_ready       out  1      op consumed this cycle; 0 = stall upstream
// - pc,instr,pc_4  in   PC/DATA/PC  op identity, passed through
// - reg_wen        in   1      writeback enable
// - reg_wb_sel     in   WB_SEL_WIDTH  writeback mux select
// - reg_waddr      in   REG_ADDR_WIDTH  destination register
// - alu_out        in   DATA   ALU result; byte address for load/store
// - store_data     in   DATA   rs2 value for stores
// - mem_ren        in   1      op is a load
// - mem_wen        in   1      op is a store
// - funct3         in   3      RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
// - dmem_req_valid out  1      bus request valid
// - dmem_req_ready in   1      bus accepts request
// - dmem_addr      out  DATA   word-aligned address {alu_out[31:2],2'b00}
// - dmem_wen       out  1      1 = write
// - dmem_wdata     out  DATA   store data replicated to all lanes
// - dmem_wstrb     out  4      byte enables
// - dmem_rsp_valid in   1      read data valid (loads only)
// - dmem_rdata     in   DATA   read data
// - out_valid      out  1      result valid toward MEM/WB
// - out_pc,out_instr,out_pc_4,out_reg_wb_sel,out_reg_waddr,out_alu_out  out  as inputs  op fields
// - out_reg_wen    out  1      reg_wen & out_valid & ~misalign
// - out_mem_out    out  DATA   extended load data; 0 for non-loads
// - misalign       out  1      misaligned access flag, valid with out_valid
// BEHAVIOUR
// - FSM states: IDLE, REQ, WAIT, DONE.
// - Reset (async): state=IDLE, hold regs=0.
//   - dmem_req_valid=0, out_valid=0, out_reg_wen=0, misalign=0.
//   - in_ready=1 whenever no memory op is presented.
// - IDLE, non-mem op or misaligned mem op:
//   - Combinational pass-through, 0 latency.
//   - in_ready=1, out_valid=in_valid, out_mem_out=0.
//   - Misaligned means H with addr[0]=1, or W with addr[1:0]!=0.
//   - Misaligned op: no bus access, misalign=1, out_reg_wen=0.
// - IDLE, aligned mem op with in_valid=1:
//   - in_ready=0, out_valid=0.
//   - Capture all op fields into hold regs; go to REQ.
// - REQ:
//   - dmem_req_valid=1; addr/wen/wdata/wstrb come from hold regs and stay stable until handshake.
//   - On req_ready: store -> DONE; load -> WAIT.
// - WAIT:
//   - On rsp_valid: latch lane-select+extend(rdata, addr[1:0], funct3) into mem_out_q; go to DONE.
//   - req_valid=0.
// - DONE:
//   - out_valid=1, all outputs from hold regs.
//   - in_ready=1: retires the same upstream op; it is not reissued.
//   - Next state IDLE.
// - REQ/WAIT: in_ready=0, out_valid=0, out_reg_wen=0, other out_* driven 0.
// - wstrb: SB 4'b0001<<off; SH 4'b0011<<off; SW 4'b1111.
// - wdata: SB {4{d[7:0]}}, SH {2{d[15:0]}}, SW d.
// - Load extension: B/H sign-extend, BU/HU zero-extend, W unchanged.
// - Boundaries:
//   - rsp_valid outside WAIT is ignored.
//   - req_ready outside REQ is ignored.
//   - mem_ren&mem_wen both set: treated as a load.
//   - Async reset mid-REQ/WAIT drops req_valid immediately and abandons the op; a later response is ignored.
// - Minimum latencies: store 2 stall cycles (IDLE, REQ) then DONE; load 3 or more stall cycles.
// STRUCTURE
// - define_pipelineregs.vh: lsu_state_t enum; type_ex_mem_reg bundle used for hold regs.
// - define.vh: funct3 load/store encodings.
// - Sub-module lsu_align (combinational): wstrb/wdata lane steering and load extract/extend.
// - FSM and hold regs live in mem_lsu.
// TESTING
// - ALU op, in_valid=1, reg_wen=1, alu_out=0x1234 -> same cycle out_valid=1, out_reg_wen=1, out_alu_out=0x1234, in_ready=1.
// - LB addr=0x103, rdata=0x80FF_0000, ready/rsp 0-wait -> out_mem_out=0xFFFF_FF80, in_ready=1 only in DONE.
// - SH addr=0x102, store_data=0xABCD, req_ready low 3 cycles -> req stable; wstrb=4'b1100, wdata=0xABCD_ABCD, dmem_addr=0x100.
// - LW addr=0x101 -> no dmem_req_valid; misalign=1, out_reg_wen=0, out_valid=1 same cycle.
// - LHU addr=0x202 in WAIT, assert rst -> req_valid=0, state IDLE; following rsp_valid has no effect.
// - Back-to-back LW, SW: each retires exactly once; no duplicate bus request; out_valid pulses once per op.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared types and encodings for the MEM-stage load/store unit.
// No logic of its own; widths match the RV32 defaults of mem_lsu.
// Hold-register bundle and FSM state live here so the top and bench agree.
package mem_lsu_pkg;

    localparam int LSU_DATA_W   = 32;
    localparam int LSU_PC_W     = 32;
    localparam int LSU_RADDR_W  = 5;
    localparam int LSU_WBSEL_W  = 2;

    // RV32 load/store size and sign encodings (funct3)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    // EX/MEM op as captured into the hold registers
    typedef struct packed {
        logic [LSU_PC_W-1:0]    pc;
        logic [LSU_DATA_W-1:0]  instr;
        logic [LSU_PC_W-1:0]    pc_4;
        logic                   reg_wen;
        logic [LSU_WBSEL_W-1:0] reg_wb_sel;
        logic [LSU_RADDR_W-1:0] reg_waddr;
        logic [LSU_DATA_W-1:0]  alu_out;
        logic [LSU_DATA_W-1:0]  store_data;
        logic                   mem_ren;
        logic                   mem_wen;
        logic [2:0]             funct3;
    } ex_mem_t;

    // Halfwords need an even address, words a 4-byte aligned one
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering: store strobes/replicated data and load extract/extend.
// Purely combinational, zero latency.
// No flow control; follows its inputs every cycle.
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [1:0]            addr_off,
    input  logic [2:0]            funct3,
    input  logic [LSU_DATA_W-1:0] store_data,
    input  logic [LSU_DATA_W-1:0] rdata,
    output logic [3:0]            wstrb,
    output logic [LSU_DATA_W-1:0] wdata,
    output logic [LSU_DATA_W-1:0] load_data
);

    logic [LSU_DATA_W-1:0] lane;

    // Store side: replicate the datum to every lane, strobe only the addressed bytes
    always_comb begin
        wstrb = 4'b1111;
        wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                wstrb = 4'b0001 << addr_off;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                wstrb = 4'b0011 << addr_off;
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                wstrb = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    // Load side: shift the addressed byte/half down to bit 0, then extend
    always_comb begin
        lane      = rdata >> {addr_off, 3'b000};
        load_data = rdata;
        case (funct3)
            F3_B:    load_data = {{24{lane[7]}}, lane[7:0]};
            F3_H:    load_data = {{16{lane[15]}}, lane[15:0]};
            F3_BU:   load_data = {24'h0, lane[7:0]};
            F3_HU:   load_data = {16'h0, lane[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: drives the dmem valid/ready bus, feeds MEM/WB.
// Latency: non-mem/misaligned ops 0 cycles; store >=2 stall cycles, load >=3.
// Backpressure: in_ready low from op capture until DONE; DONE retires the op.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = LSU_DATA_W,
    parameter int PC_WIDTH       = LSU_PC_W,
    parameter int REG_ADDR_WIDTH = LSU_RADDR_W,
    parameter int WB_SEL_WIDTH   = LSU_WBSEL_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PC_WIDTH-1:0]       pc,
    input  logic [DATA_WIDTH-1:0]     instr,
    input  logic [PC_WIDTH-1:0]       pc_4,
    input  logic                      reg_wen,
    input  logic [WB_SEL_WIDTH-1:0]   reg_wb_sel,
    input  logic [REG_ADDR_WIDTH-1:0] reg_waddr,
    input  logic [DATA_WIDTH-1:0]     alu_out,
    input  logic [DATA_WIDTH-1:0]     store_data,
    input  logic                      mem_ren,
    input  logic                      mem_wen,
    input  logic [2:0]                funct3,
    output logic                      dmem_req_valid,
    input  logic                      dmem_req_ready,
    output logic [DATA_WIDTH-1:0]     dmem_addr,
    output logic                      dmem_wen,
    output logic [DATA_WIDTH-1:0]     dmem_wdata,
    output logic [3:0]                dmem_wstrb,
    input  logic                      dmem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     dmem_rdata,
    output logic                      out_valid,
    output logic [PC_WIDTH-1:0]       out_pc,
    output logic [DATA_WIDTH-1:0]     out_instr,
    output logic [PC_WIDTH-1:0]       out_pc_4,
    output logic                      out_reg_wen,
    output logic [WB_SEL_WIDTH-1:0]   out_reg_wb_sel,
    output logic [REG_ADDR_WIDTH-1:0] out_reg_waddr,
    output logic [DATA_WIDTH-1:0]     out_alu_out,
    output logic [DATA_WIDTH-1:0]     out_mem_out,
    output logic                      misalign
);

    lsu_state_t            state_q, state_d;
    ex_mem_t               hold_q, hold_d;
    logic [DATA_WIDTH-1:0] mem_out_q, mem_out_d;
    ex_mem_t               in_op;
    logic                  in_is_mem;
    logic                  in_misalign;
    logic                  hold_is_load;
    logic [DATA_WIDTH-1:0] ld_data;

    assign in_op = '{pc: pc, instr: instr, pc_4: pc_4, reg_wen: reg_wen,
                     reg_wb_sel: reg_wb_sel, reg_waddr: reg_waddr, alu_out: alu_out,
                     store_data: store_data, mem_ren: mem_ren, mem_wen: mem_wen,
                     funct3: funct3};

    assign in_is_mem    = mem_ren | mem_wen;
    assign in_misalign  = in_is_mem & is_misaligned(funct3, alu_out[1:0]);
    // A stray op with both flags set is a load; it never writes memory
    assign hold_is_load = hold_q.mem_ren;

    // Bus fields come straight from the hold regs so they stay stable across REQ
    assign dmem_addr = {hold_q.alu_out[DATA_WIDTH-1:2], 2'b00};
    assign dmem_wen  = hold_q.mem_wen & ~hold_q.mem_ren;

    mem_lsu_align u_align (
        .addr_off   (hold_q.alu_out[1:0]),
        .funct3     (hold_q.funct3),
        .store_data (hold_q.store_data),
        .rdata      (dmem_rdata),
        .wstrb      (dmem_wstrb),
        .wdata      (dmem_wdata),
        .load_data  (ld_data)
    );

    // State and hold registers; reset abandons any in-flight access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            mem_out_q <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            mem_out_q <= mem_out_d;
        end
    end

    // Next state, hold-reg capture and all handshake/result outputs
    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        mem_out_d      = mem_out_q;
        in_ready       = 1'b0;
        out_valid      = 1'b0;
        dmem_req_valid = 1'b0;
        out_pc         = '0;
        out_instr      = '0;
        out_pc_4       = '0;
        out_reg_wen    = 1'b0;
        out_reg_wb_sel = '0;
        out_reg_waddr  = '0;
        out_alu_out    = '0;
        out_mem_out    = '0;
        misalign       = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && in_is_mem && !in_misalign) begin
                    hold_d    = in_op;
                    mem_out_d = '0;
                    state_d   = REQ;
                end else begin
                    // Zero-latency pass-through; misaligned ops never touch the bus
                    in_ready       = 1'b1;
                    out_valid      = in_valid;
                    out_pc         = pc;
                    out_instr      = instr;
                    out_pc_4       = pc_4;
                    out_reg_wen    = in_valid & reg_wen & ~in_misalign;
                    out_reg_wb_sel = reg_wb_sel;
                    out_reg_waddr  = reg_waddr;
                    out_alu_out    = alu_out;
                    misalign       = in_valid & in_misalign;
                end
            end
            REQ: begin
                dmem_req_valid = 1'b1;
                if (dmem_req_ready) begin
                    state_d = hold_is_load ? WAIT : DONE;
                end
            end
            WAIT: begin
                if (dmem_rsp_valid) begin
                    mem_out_d = ld_data;
                    state_d   = DONE;
                end
            end
            DONE: begin
                in_ready       = 1'b1;
                out_valid      = 1'b1;
                out_pc         = hold_q.pc;
                out_instr      = hold_q.instr;
                out_pc_4       = hold_q.pc_4;
                out_reg_wen    = hold_q.reg_wen;
                out_reg_wb_sel = hold_q.reg_wb_sel;
                out_reg_waddr  = hold_q.reg_waddr;
                out_alu_out    = hold_q.alu_out;
                out_mem_out    = mem_out_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios plus randomized ops.
// Expected results come from size/offset arithmetic on each op, not the RTL.
// Bus responder is scripted per op with chosen ready/response delays.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] pc = '0, instr = '0, pc_4 = '0;
    logic        reg_wen = 1'b0;
    logic [1:0]  reg_wb_sel = '0;
    logic [4:0]  reg_waddr = '0;
    logic [31:0] alu_out = '0, store_data = '0;
    logic        mem_ren = 1'b0, mem_wen = 1'b0;
    logic [2:0]  funct3 = '0;
    logic        dmem_req_valid;
    logic        dmem_req_ready = 1'b0;
    logic [31:0] dmem_addr;
    logic        dmem_wen;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_rsp_valid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        out_valid;
    logic [31:0] out_pc, out_instr, out_pc_4;
    logic        out_reg_wen;
    logic [1:0]  out_reg_wb_sel;
    logic [4:0]  out_reg_waddr;
    logic [31:0] out_alu_out, out_mem_out;
    logic        misalign;

    int total = 0;
    int bad = 0;
    int hs_cnt = 0;
    int ov_cnt = 0;

    mem_lsu dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .instr(instr), .pc_4(pc_4), .reg_wen(reg_wen),
        .reg_wb_sel(reg_wb_sel), .reg_waddr(reg_waddr), .alu_out(alu_out),
        .store_data(store_data), .mem_ren(mem_ren), .mem_wen(mem_wen), .funct3(funct3),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_pc_4(out_pc_4),
        .out_reg_wen(out_reg_wen), .out_reg_wb_sel(out_reg_wb_sel),
        .out_reg_waddr(out_reg_waddr), .out_alu_out(out_alu_out),
        .out_mem_out(out_mem_out), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Count bus handshakes and result pulses for the retire-once checks
    always @(posedge clk) begin
        if (dmem_req_valid && dmem_req_ready) hs_cnt++;
        if (out_valid) ov_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int ref_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % ref_size(f3)) != 0;
    endfunction

    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
        return 4'(((1 << ref_size(f3)) - 1) << a[1:0]);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (ref_size(f3))
            1:       return 32'(32'h0101_0101 * d[7:0]);
            2:       return 32'(32'h0001_0001 * d[15:0]);
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [2:0] f3);
        logic [31:0]        sh;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        sh = rd >> (8 * off);
        b  = sh[7:0];
        h  = sh[15:0];
        case (f3)
            3'b000:  return 32'(b);
            3'b001:  return 32'(h);
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return rd;
        endcase
    endfunction

    // ---------------- one op, cycle by cycle ----------------
    // Drives an op at posedge+1, scripts the bus, checks every cycle until retire.
    task automatic run_op(input string nm, input logic ren, input logic wen,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata,
                          input int req_wait, input int rsp_wait);
        logic [31:0] opc, oin, op4, exp_mo;
        logic        owen, is_mem, mis, ld;
        logic [1:0]  osel;
        logic [4:0]  owa;
        opc  = $urandom; oin = $urandom; op4 = opc + 32'd4;
        owen = 1'($urandom); osel = 2'($urandom); owa = 5'($urandom);
        in_valid = 1'b1; pc = opc; instr = oin; pc_4 = op4; reg_wen = owen;
        reg_wb_sel = osel; reg_waddr = owa; alu_out = addr; store_data = sdata;
        mem_ren = ren; mem_wen = wen; funct3 = f3;
        dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
        is_mem = ren | wen;
        mis    = is_mem && ref_mis(f3, addr);
        ld     = ren;
        exp_mo = ld ? ref_load(rdata, addr[1:0], f3) : 32'h0;
        @(negedge clk);
        if (!is_mem || mis) begin
            total++;
            if ({in_ready, out_valid, dmem_req_valid, out_reg_wen, misalign} !==
                {1'b1, 1'b1, 1'b0, owen & ~mis, mis}) begin
                bad++;
                $display("FAIL %s passthru ctl: got %b want %b", nm,
                         {in_ready, out_valid, dmem_req_valid, out_reg_wen, misalign},
                         {1'b1, 1'b1, 1'b0, owen & ~mis, mis});
            end
            total++;
            if ({out_pc, out_instr, out_pc_4, out_alu_out, out_reg_wb_sel, out_reg_waddr, out_mem_out} !==
                {opc, oin, op4, addr, osel, owa, 32'h0}) begin
                bad++;
                $display("FAIL %s passthru fields: got alu=%h mo=%h want alu=%h mo=0",
                         nm, out_alu_out, out_mem_out, addr);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            return;
        end
        // Capture cycle: stalled, nothing valid yet
        total++;
        if ({in_ready, out_valid, dmem_req_valid} !== 3'b000) begin
            bad++;
            $display("FAIL %s capture: got %b want 000", nm, {in_ready, out_valid, dmem_req_valid});
        end
        @(posedge clk); #1;
        // Upstream fields are scrambled: results must come from captured copies
        pc = $urandom; instr = $urandom; alu_out = $urandom; store_data = $urandom;
        funct3 = 3'($urandom); reg_wen = 1'($urandom); reg_waddr = 5'($urandom);
        for (int i = 0; i <= req_wait; i++) begin
            dmem_req_ready = (i == req_wait);
            dmem_rsp_valid = 1'($urandom);
            dmem_rdata     = $urandom;
            @(negedge clk);
            total++;
            if ({dmem_req_valid, in_ready, out_valid, dmem_addr, dmem_wen} !==
                {1'b1, 1'b0, 1'b0, addr[31:2], 2'b00, ~ld}) begin
                bad++;
                $display("FAIL %s req: got v=%b rdy=%b ov=%b a=%h w=%b want 1 0 0 %h %b", nm,
                         dmem_req_valid, in_ready, out_valid, dmem_addr, dmem_wen,
                         {addr[31:2], 2'b00}, ~ld);
            end
            if (!ld) begin
                total++;
                if ({dmem_wstrb, dmem_wdata} !== {ref_strb(f3, addr), ref_wdata(f3, sdata)}) begin
                    bad++;
                    $display("FAIL %s store lanes: got strb=%b data=%h want strb=%b data=%h", nm,
                             dmem_wstrb, dmem_wdata, ref_strb(f3, addr), ref_wdata(f3, sdata));
                end
            end
            @(posedge clk); #1;
        end
        dmem_rsp_valid = 1'b0;
        if (ld) begin
            for (int i = 0; i <= rsp_wait; i++) begin
                dmem_req_ready = 1'($urandom);
                dmem_rsp_valid = (i == rsp_wait);
                dmem_rdata     = (i == rsp_wait) ? rdata : $urandom;
                @(negedge clk);
                total++;
                if ({dmem_req_valid, in_ready, out_valid} !== 3'b000) begin
                    bad++;
                    $display("FAIL %s wait: got %b want 000", nm,
                             {dmem_req_valid, in_ready, out_valid});
                end
                @(posedge clk); #1;
            end
        end
        // DONE: results from captured op, stray bus activity ignored
        dmem_req_ready = 1'($urandom);
        dmem_rsp_valid = 1'($urandom);
        dmem_rdata     = $urandom;
        @(negedge clk);
        total++;
        if ({in_ready, out_valid, dmem_req_valid, out_reg_wen, misalign} !==
            {1'b1, 1'b1, 1'b0, owen, 1'b0}) begin
            bad++;
            $display("FAIL %s done ctl: got %b want %b", nm,
                     {in_ready, out_valid, dmem_req_valid, out_reg_wen, misalign},
                     {1'b1, 1'b1, 1'b0, owen, 1'b0});
        end
        total++;
        if ({out_pc, out_instr, out_pc_4, out_alu_out, out_reg_wb_sel, out_reg_waddr, out_mem_out} !==
            {opc, oin, op4, addr, osel, owa, exp_mo}) begin
            bad++;
            $display("FAIL %s done fields: got pc=%h alu=%h mo=%h want pc=%h alu=%h mo=%h", nm,
                     out_pc, out_alu_out, out_mem_out, opc, addr, exp_mo);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0;
        #1;
        total++;
        if ({in_ready, out_valid, dmem_req_valid, out_reg_wen, misalign} !== 5'b10000) begin
            bad++;
            $display("FAIL reset: got %b want 10000",
                     {in_ready, out_valid, dmem_req_valid, out_reg_wen, misalign});
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        in_valid = 1'b1; reg_wen = 1'b1; alu_out = 32'h1234; mem_ren = 1'b0; mem_wen = 1'b0;
        funct3 = 3'b010;
        @(negedge clk);
        total++;
        if ({out_valid, out_reg_wen, in_ready, misalign, dmem_req_valid, out_alu_out} !==
            {5'b11100, 32'h1234}) begin
            bad++;
            $display("FAIL alu: got v=%b wen=%b rdy=%b alu=%h want 1 1 1 00001234",
                     out_valid, out_reg_wen, in_ready, out_alu_out);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        run_op("alu_rand", 1'b0, 1'b0, 3'($urandom), $urandom, $urandom, $urandom, 0, 0);
    endtask

    task automatic test_load_store();
        run_op("lb_103",    1'b1, 1'b0, F3_B,  32'h103, $urandom, 32'h80FF_0000, 0, 0);
        run_op("sh_102",    1'b0, 1'b1, F3_H,  32'h102, 32'h0000_ABCD, $urandom, 3, 0);
        run_op("lhu_206",   1'b1, 1'b0, F3_HU, 32'h206, $urandom, 32'h8765_4321, 1, 2);
        run_op("lw_200",    1'b1, 1'b0, F3_W,  32'h200, $urandom, 32'hDEAD_BEEF, 2, 3);
        run_op("sb_301",    1'b0, 1'b1, F3_B,  32'h301, 32'h1234_5677, $urandom, 0, 0);
        run_op("both_ld",   1'b1, 1'b1, F3_BU, 32'h402, $urandom, 32'h00F0_0000, 1, 1);
    endtask

    task automatic test_misalign();
        int h0;
        h0 = hs_cnt;
        run_op("lw_101", 1'b1, 1'b0, F3_W, 32'h101, $urandom, $urandom, 0, 0);
        run_op("sh_103", 1'b0, 1'b1, F3_H, 32'h103, $urandom, $urandom, 0, 0);
        total++;
        if (hs_cnt !== h0) begin
            bad++;
            $display("FAIL misalign bus: got %0d handshakes want 0", hs_cnt - h0);
        end
    endtask

    task automatic test_reset_mid_req();
        in_valid = 1'b1; mem_ren = 1'b0; mem_wen = 1'b1; funct3 = F3_W; alu_out = 32'h500;
        dmem_req_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        #2 rst = 1'b1; in_valid = 1'b0;
        #1;
        total++;
        if ({dmem_req_valid, in_ready, out_valid} !== 3'b010) begin
            bad++;
            $display("FAIL rst_req drop: got %b want 010", {dmem_req_valid, in_ready, out_valid});
        end
        @(posedge clk); #1 rst = 1'b0;
        dmem_req_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({dmem_req_valid, out_valid} !== 2'b00) begin
            bad++;
            $display("FAIL rst_req after: got %b want 00", {dmem_req_valid, out_valid});
        end
        @(posedge clk); #1 dmem_req_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        in_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; funct3 = F3_HU; alu_out = 32'h202;
        @(posedge clk); #1 dmem_req_ready = 1'b1;
        @(posedge clk); #1 dmem_req_ready = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1; in_valid = 1'b0;
        #1;
        total++;
        if ({dmem_req_valid, in_ready, out_valid} !== 3'b010) begin
            bad++;
            $display("FAIL rst_wait idle: got %b want 010", {dmem_req_valid, in_ready, out_valid});
        end
        @(posedge clk); #1 rst = 1'b0;
        dmem_rsp_valid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1 dmem_rsp_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({out_valid, in_ready, out_mem_out} !== {2'b01, 32'h0}) begin
            bad++;
            $display("FAIL rst_wait late rsp: got v=%b rdy=%b mo=%h want 0 1 0",
                     out_valid, in_ready, out_mem_out);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int h0, v0;
        h0 = hs_cnt; v0 = ov_cnt;
        run_op("b2b_lw", 1'b1, 1'b0, F3_W, 32'h600, $urandom, 32'h1357_9BDF, 0, 0);
        run_op("b2b_sw", 1'b0, 1'b1, F3_W, 32'h604, 32'hCAFE_F00D, $urandom, 0, 0);
        @(negedge clk);
        total++;
        if ({hs_cnt - h0, ov_cnt - v0} !== {32'd2, 32'd2}) begin
            bad++;
            $display("FAIL b2b counts: got hs=%0d ov=%0d want 2 2", hs_cnt - h0, ov_cnt - v0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [2:0] ld_f3 [5];
        ld_f3 = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        for (int n = 0; n < 80; n++) begin
            int          k;
            logic [2:0]  f;
            k = $urandom_range(0, 3);
            f = (k == 2) ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            run_op($sformatf("rand%0d_k%0d", n, k), (k == 1 || k == 3), (k >= 2), f,
                   $urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_misalign();
        test_reset_mid_req();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
